// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target (responder) for the peripherals register window.
//
// An external master drives sclk/cs_n/mosi asynchronously; every pin is
// oversampled in the raw_clk domain through SYNC_STAGES flops plus one history
// flop for edge detection. Frames are 8 or 16 bits, MSB first. Several frames
// may run back to back inside one cs_n low period.
//
// Build option:
//   SPI_TARGET_FIFO_EN  defined   -> data_rx/rx_valid front a 4-entry RX FIFO
//                       undefined -> single rx holding register (default)
//
// Ports:
//   raw_clk   in   clock for all logic
//   reset     in   synchronous, active-high
//   width_16  in   frame width (1 = 16 bits, 0 = 8 bits), latched when cs_n falls
//   data_tx   in   next word to transmit
//   tx_load   in   one-cycle pulse: data_tx -> tx holding register
//   tx_empty  out  tx holding register consumed or never loaded
//   data_rx   out  last committed rx word (8-bit frames zero-extended)
//   rx_valid  out  data_rx holds unread data
//   rx_read   in   one-cycle pulse: consume rx word, clear overrun
//   overrun   out  sticky: a frame completed with nowhere to put it
//   busy      out  a frame sequence is active (synchronized cs_n low)
//   sclk      in   serial clock from master (async)
//   cs_n      in   chip select from master (async, active-low)
//   mosi      in   serial data from master (async)
//   miso      out  serial data to master (registered)
//   fsm_state out  debug view of the FSM (0 = IDLE, 1 = SHIFT)
//
// Handshakes: tx_load and rx_read are single-cycle strobes from the CPU side.
// A word is offered while rx_valid=1 and is taken in the cycle rx_read=1;
// tx_empty=1 means the CPU may load a new word without overwriting one that
// has not yet been sent.

module spi_target #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b1
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        width_16,
    input  logic [15:0] data_tx,
    input  logic        tx_load,
    output logic        tx_empty,
    output logic [15:0] data_rx,
    output logic        rx_valid,
    input  logic        rx_read,
    output logic        overrun,
    output logic        busy,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        fsm_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers. Deliberately not reset: they keep tracking the pins
    // through reset, so a cs_n that was already low when reset released does
    // not look like a fresh falling edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_hist;
    logic                   cs_hist;

    always_ff @(posedge raw_clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        sclk_hist <= sclk_sync[SYNC_STAGES-1];
        cs_hist   <= cs_sync[SYNC_STAGES-1];
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_rise   = cs_s & ~cs_hist;
    assign cs_fall   = ~cs_s & cs_hist;

    // ------------------------------------------------------------------
    // Frame control
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [4:0]  bit_cnt;
    logic        w16_q;
    logic [15:0] tx_sh;
    logic [15:0] rx_sh;
    logic        miso_q;
    logic        busy_q;
    logic [15:0] tx_hold;
    logic        tx_empty_q;

    logic        frame_done;
    logic        start;
    logic        reload;
    logic        commit;
    logic        w_next;
    logic [15:0] tx_src;
    logic [15:0] tx_word;
    logic [15:0] rx_word;

    // The counter is registered, so the commit lands one cycle after the
    // final shift; sclk is slow enough that no edge is lost in that cycle.
    assign frame_done = (state_q == SHIFT) && (bit_cnt == (w16_q ? 5'd16 : 5'd8));
    assign start      = (state_q == IDLE) && cs_fall;
    assign commit     = frame_done;
    assign reload     = start || (frame_done && !cs_rise);
    assign w_next     = start ? width_16 : w16_q;
    assign tx_src     = tx_empty_q ? 16'h0000 : tx_hold;
    // 8-bit words are left-aligned so the outgoing bit is always tx_sh[15].
    assign tx_word    = w_next ? tx_src : {tx_src[7:0], 8'h00};
    assign rx_word    = w16_q ? rx_sh : {8'h00, rx_sh[7:0]};

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_cnt <= 5'd0;
            w16_q   <= 1'b0;
            tx_sh   <= 16'h0000;
            rx_sh   <= 16'h0000;
            miso_q  <= IDLE_MISO;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        w16_q   <= width_16;
                        bit_cnt <= 5'd0;
                        tx_sh   <= tx_word;
                        miso_q  <= tx_word[15];
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        bit_cnt <= 5'd0;
                        miso_q  <= IDLE_MISO;
                    end else if (frame_done) begin
                        bit_cnt <= 5'd0;
                        tx_sh   <= tx_word;
                        miso_q  <= tx_word[15];
                    end else begin
                        if (sclk_rise) begin
                            rx_sh   <= {rx_sh[14:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        // A fall with bit_cnt=0 is the trailing fall of the
                        // previous frame; the freshly loaded MSB must stay.
                        if (sclk_fall && (bit_cnt != 5'd0)) begin
                            tx_sh  <= {tx_sh[14:0], 1'b0};
                            miso_q <= tx_sh[14];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // tx holding register: a load in the same cycle as a reload wins, the
    // reload itself already used the old holding value.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            tx_hold    <= 16'h0000;
            tx_empty_q <= 1'b1;
        end else if (tx_load) begin
            tx_hold    <= data_tx;
            tx_empty_q <= 1'b0;
        end else if (reload) begin
            tx_empty_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
`ifdef SPI_TARGET_FIFO_EN
    logic [15:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        ovr_q;
    logic        full;
    logic        push;
    logic        pop;
    logic        drop;

    assign full = (count == 3'd4);
    // On a full FIFO a simultaneous read frees the slot the commit needs.
    assign push = commit && (!full || rx_read);
    assign pop  = rx_read && (count != 3'd0);
    assign drop = commit && full && !rx_read;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 16'h0000;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            ovr_q  <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rx_word;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
            ovr_q <= rx_read ? 1'b0 : (ovr_q | drop);
        end
    end

    assign data_rx  = fifo_mem[rd_ptr];
    assign rx_valid = (count != 3'd0);
    assign overrun  = ovr_q;
`else
    logic [15:0] data_rx_q;
    logic        rx_valid_q;
    logic        ovr_q;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            data_rx_q  <= 16'h0000;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            // A read in the commit cycle frees the register for the new word.
            if (commit && (!rx_valid_q || rx_read)) begin
                data_rx_q  <= rx_word;
                rx_valid_q <= 1'b1;
            end else if (rx_read) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_read) begin
                ovr_q <= 1'b0;
            end else if (commit && rx_valid_q) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign data_rx  = data_rx_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = ovr_q;
`endif

    assign tx_empty  = tx_empty_q;
    assign busy      = busy_q;
    assign miso      = miso_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

    localparam int HALF = 80;  // sclk half period, 8 raw_clk cycles

    logic        raw_clk = 1'b0;
    logic        reset;
    logic        width_16;
    logic [15:0] data_tx;
    logic        tx_load;
    logic        tx_empty;
    logic [15:0] data_rx;
    logic        rx_valid;
    logic        rx_read;
    logic        overrun;
    logic        busy;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        fsm_state;

    spi_target #(
        .SYNC_STAGES(2),
        .IDLE_MISO  (1'b1)
    ) dut (
        .raw_clk  (raw_clk),
        .reset    (reset),
        .width_16 (width_16),
        .data_tx  (data_tx),
        .tx_load  (tx_load),
        .tx_empty (tx_empty),
        .data_rx  (data_rx),
        .rx_valid (rx_valid),
        .rx_read  (rx_read),
        .overrun  (overrun),
        .busy     (busy),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 raw_clk = ~raw_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge raw_clk);
            if (rx_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: got word %h with no expected entry", data_rx);
                end else begin
                    check("rx_word", data_rx, exp_q.pop_front());
                end
            end
            prev = rx_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_load(input logic [15:0] d);
        @(negedge raw_clk);
        data_tx = d;
        tx_load = 1'b1;
        @(negedge raw_clk);
        tx_load = 1'b0;
    endtask

    task automatic pulse_read();
        @(negedge raw_clk);
        rx_read = 1'b1;
        @(negedge raw_clk);
        rx_read = 1'b0;
    endtask

    task automatic spi_begin();
        cs_n = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        cs_n = 1'b1;
        #HALF;
        #HALF;
    endtask

    // Sends d[n-1:0] MSB first; returns miso bits sampled before each rise.
    task automatic spi_bits(input int n, input logic [15:0] d, output logic [15:0] got);
        got = 16'h0000;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            #HALF;
            got  = {got[14:0], miso};
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic wait_rx(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge raw_clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, %0d expected words pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_rx"}, data_rx, 16'h0000);
        check({tag, "_rx_valid"}, {15'b0, rx_valid}, 16'h0000);
        check({tag, "_overrun"}, {15'b0, overrun}, 16'h0000);
        check({tag, "_busy"}, {15'b0, busy}, 16'h0000);
        check({tag, "_tx_empty"}, {15'b0, tx_empty}, 16'h0001);
        check({tag, "_miso"}, {15'b0, miso}, 16'h0001);
        check({tag, "_state"}, {15'b0, fsm_state}, 16'h0000);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [15:0] got;

        reset    = 1'b1;
        width_16 = 1'b0;
        data_tx  = 16'h0000;
        tx_load  = 1'b0;
        rx_read  = 1'b0;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        repeat (5) @(negedge raw_clk);
        reset = 1'b0;
        @(negedge raw_clk);
        check_reset_values("rst");

        // 1: 16-bit frame, tx A55A, master sends 1234
        width_16 = 1'b1;
        pulse_load(16'hA55A);
        check("t1_tx_full", {15'b0, tx_empty}, 16'h0000);
        exp_q.push_back(16'h1234);
        spi_begin();
        check("t1_busy", {15'b0, busy}, 16'h0001);
        check("t1_tx_consumed", {15'b0, tx_empty}, 16'h0001);
        spi_bits(16, 16'h1234, got);
        check("t1_miso_word", got, 16'hA55A);
        wait_rx("t1_rx");
        spi_end();
        check("t1_rx_valid", {15'b0, rx_valid}, 16'h0001);
        check("t1_busy_end", {15'b0, busy}, 16'h0000);
        check("t1_miso_idle", {15'b0, miso}, 16'h0001);
        pulse_read();
        check("t1_rx_cleared", {15'b0, rx_valid}, 16'h0000);

        // 2: 8-bit frame, only tx[7:0] goes out; width change mid-frame ignored
        width_16 = 1'b0;
        pulse_load(16'hFFC3);
        exp_q.push_back(16'h0081);
        spi_begin();
        width_16 = 1'b1;
        spi_bits(8, 16'h0081, got);
        check("t2_miso_word", got, 16'h00C3);
        wait_rx("t2_rx");
        spi_end();
        check("t2_data_rx", data_rx, 16'h0081);
        pulse_read();
        width_16 = 1'b0;

        // 3: back-to-back frames without a read -> overrun, first word kept
        pulse_load(16'h005A);
        exp_q.push_back(16'h0011);
        spi_begin();
        spi_bits(8, 16'h0011, got);
        check("t3_miso_first", got, 16'h005A);
        spi_bits(8, 16'h0022, got);
        check("t3_miso_empty", got, 16'h0000);
        wait_rx("t3_rx");
        spi_end();
        check("t3_data_kept", data_rx, 16'h0011);
        check("t3_rx_valid", {15'b0, rx_valid}, 16'h0001);
        check("t3_overrun", {15'b0, overrun}, 16'h0001);
        pulse_read();
        check("t3_rx_cleared", {15'b0, rx_valid}, 16'h0000);
        check("t3_overrun_cleared", {15'b0, overrun}, 16'h0000);

        // 4: cs_n rises after 5 bits -> discarded, tx still consumed
        pulse_load(16'h003C);
        spi_begin();
        spi_bits(5, 16'h0016, got);
        check("t4_partial_miso", got, 16'h0007);
        spi_end();
        check("t4_no_rx", {15'b0, rx_valid}, 16'h0000);
        check("t4_busy", {15'b0, busy}, 16'h0000);
        check("t4_miso_idle", {15'b0, miso}, 16'h0001);
        check("t4_tx_consumed", {15'b0, tx_empty}, 16'h0001);
        exp_q.push_back(16'h00A7);
        spi_begin();
        spi_bits(8, 16'h00A7, got);
        check("t4_next_miso", got, 16'h0000);
        wait_rx("t4_rx");
        spi_end();

        // 5: reset at bit 6 of a 16-bit frame (rx_valid still set from t4)
        width_16 = 1'b1;
        pulse_load(16'hBEEF);
        spi_begin();
        spi_bits(6, 16'h002A, got);
        check("t5_pre_reset_miso", got, 16'h002F);
        @(negedge raw_clk);
        reset = 1'b1;
        repeat (2) @(negedge raw_clk);
        reset = 1'b0;
        @(negedge raw_clk);
        check_reset_values("t5");
        spi_bits(10, 16'h0155, got);
        check("t5_ignored_miso", got, 16'h03FF);
        check("t5_ignored_rx", {15'b0, rx_valid}, 16'h0000);
        check("t5_ignored_busy", {15'b0, busy}, 16'h0000);
        check("t5_ignored_state", {15'b0, fsm_state}, 16'h0000);
        spi_end();
        pulse_load(16'h1357);
        exp_q.push_back(16'hC0DE);
        spi_begin();
        spi_bits(16, 16'hC0DE, got);
        check("t5_after_miso", got, 16'h1357);
        wait_rx("t5_rx");
        spi_end();
        pulse_read();

`ifdef SPI_TARGET_FIFO_EN
        // 6: five frames into a 4-entry FIFO
        width_16 = 1'b0;
        exp_q.push_back(16'h0001);
        spi_begin();
        for (int k = 1; k <= 5; k++) begin
            spi_bits(8, 16'(k), got);
        end
        spi_end();
        wait_rx("t6_rx");
        check("t6_overrun", {15'b0, overrun}, 16'h0001);
        for (int k = 1; k <= 4; k++) begin
            check("t6_pop", data_rx, 16'(k));
            pulse_read();
        end
        check("t6_empty", {15'b0, rx_valid}, 16'h0000);
        check("t6_overrun_cleared", {15'b0, overrun}, 16'h0000);
`endif

        repeat (10) @(negedge raw_clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL end_queue: %0d expected words pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
